// File: rtl/alu_fu_pipe.sv
// Pipelined integer ALU functional unit with a valid/ready writeback port and flush.
// Optional multiplier for op 11 is enabled by defining ALU_FU_PIPE_MUL_EN.
module alu_fu_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned PREG_W = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         issue_valid_i,
    output logic                         issue_ready_o,
    input  logic [3:0]                   op_i,
    input  logic [XLEN-1:0]              src1_i,
    input  logic [XLEN-1:0]              src2_i,
    input  logic [XLEN-1:0]              imm_i,
    input  logic                         imm_used_i,
    input  logic [TAG_W-1:0]             rob_tag_i,
    input  logic                         rd_used_i,
    input  logic [PREG_W-1:0]            prd_i,
    output logic                         wb_valid_o,
    input  logic                         wb_ready_i,
    output logic [TAG_W-1:0]             wb_rob_tag_o,
    output logic                         wb_rd_used_o,
    output logic [PREG_W-1:0]            wb_prd_o,
    output logic [XLEN-1:0]              wb_data_o,
    output logic [$clog2(STAGES+1)-1:0]  occ_o
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);
    localparam int unsigned SH_W  = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_LUI  = 4'd10,
        OP_MUL  = 4'd11
    } op_e;

    logic [XLEN-1:0]   opb;
    logic [SH_W-1:0]   shamt;
    logic [XLEN-1:0]   alu_res;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [XLEN-1:0]   data_q  [STAGES];
    logic [XLEN-1:0]   data_d  [STAGES];
    logic [TAG_W-1:0]  tag_q   [STAGES];
    logic [TAG_W-1:0]  tag_d   [STAGES];
    logic              rdu_q   [STAGES];
    logic              rdu_d   [STAGES];
    logic [PREG_W-1:0] prd_q   [STAGES];
    logic [PREG_W-1:0] prd_d   [STAGES];

    logic [STAGES-1:0] ready;
    logic              gap;
    logic              accept;
    logic [OCC_W-1:0]  occ;

    always_comb begin
        opb     = imm_used_i ? imm_i : src2_i;
        shamt   = opb[SH_W-1:0];
        alu_res = '0;
        case (op_i)
            OP_ADD:  alu_res = src1_i + opb;
            OP_SUB:  alu_res = src1_i - opb;
            OP_AND:  alu_res = src1_i & opb;
            OP_OR:   alu_res = src1_i | opb;
            OP_XOR:  alu_res = src1_i ^ opb;
            OP_SLL:  alu_res = src1_i << shamt;
            OP_SRL:  alu_res = src1_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(src1_i) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src1_i) < $signed(opb))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src1_i < opb)};
            OP_LUI:  alu_res = opb;
`ifdef ALU_FU_PIPE_MUL_EN
            OP_MUL:  alu_res = src1_i * opb;
`endif
            default: alu_res = '0;
        endcase
    end

    // A stage can take new content if it or any stage downstream of it is empty,
    // or the writeback port is draining; bubbles still shift in order.
    always_comb begin
        ready = '0;
        gap   = wb_ready_i;
        for (int unsigned i = 0; i < STAGES; i++) begin
            gap = gap | ~valid_q[STAGES-1-i];
            ready[STAGES-1-i] = gap;
        end
    end

    assign issue_ready_o = ready[0];
    assign accept        = issue_valid_i && ready[0] && !flush_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        rdu_d   = rdu_q;
        prd_d   = prd_q;
        for (int unsigned k = 1; k < STAGES; k++) begin
            if (ready[k]) begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = data_q[k-1];
                tag_d[k]   = tag_q[k-1];
                rdu_d[k]   = rdu_q[k-1];
                prd_d[k]   = prd_q[k-1];
            end
        end
        if (ready[0]) begin
            valid_d[0] = accept;
            data_d[0]  = alu_res;
            tag_d[0]   = rob_tag_i;
            rdu_d[0]   = rd_used_i;
            prd_d[0]   = prd_i;
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
                rdu_q[k]  <= 1'b0;
                prd_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            rdu_q   <= rdu_d;
            prd_q   <= prd_d;
        end
    end

    always_comb begin
        occ = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            occ = occ + OCC_W'(valid_q[k]);
        end
    end

    assign occ_o        = occ;
    assign wb_valid_o   = valid_q[STAGES-1];
    assign wb_data_o    = valid_q[STAGES-1] ? data_q[STAGES-1] : '0;
    assign wb_rob_tag_o = valid_q[STAGES-1] ? tag_q[STAGES-1]  : '0;
    assign wb_rd_used_o = valid_q[STAGES-1] & rdu_q[STAGES-1];
    assign wb_prd_o     = (valid_q[STAGES-1] && rdu_q[STAGES-1]) ? prd_q[STAGES-1] : '0;

endmodule

// File: tb/tb_alu_fu_pipe.sv
// Directed self-checking bench for alu_fu_pipe at default parameters (STAGES=2, XLEN=32).
module tb_alu_fu_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush_i = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic [3:0]  op_i = '0;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic [31:0] imm_i = '0;
    logic        imm_used_i = 1'b0;
    logic [4:0]  rob_tag_i = '0;
    logic        rd_used_i = 1'b0;
    logic [5:0]  prd_i = '0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b1;
    logic [4:0]  wb_rob_tag_o;
    logic        wb_rd_used_o;
    logic [5:0]  wb_prd_o;
    logic [31:0] wb_data_o;
    logic [1:0]  occ_o;

    int unsigned assertions = 0;
    int unsigned failures = 0;

    alu_fu_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5), .PREG_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .op_i(op_i), .src1_i(src1_i), .src2_i(src2_i), .imm_i(imm_i),
        .imm_used_i(imm_used_i), .rob_tag_i(rob_tag_i), .rd_used_i(rd_used_i),
        .prd_i(prd_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rob_tag_o(wb_rob_tag_o), .wb_rd_used_o(wb_rd_used_o),
        .wb_prd_o(wb_prd_o), .wb_data_o(wb_data_o), .occ_o(occ_o)
    );

    always #5 clk = ~clk;

    // ALU vector table: op, src1, src2, imm, imm_used, rd_used, prd, expected data, expected prd
    localparam int NV = 11;
`ifdef ALU_FU_PIPE_MUL_EN
    localparam logic [31:0] MUL_EXP = 32'd42;
`else
    localparam logic [31:0] MUL_EXP = 32'd0;
`endif
    logic [3:0]  v_op   [NV] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd13, 4'd11};
    logic [31:0] v_a    [NV] = '{32'hFFFF_FFFF, 32'hF0F0, 32'hF0F0, 32'hFF, 32'd1, 32'h8000_0000,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hDEAD, 32'h1234, 32'd6};
    logic [31:0] v_b    [NV] = '{32'd1, 32'hFF00, 32'h0F00, 32'h0F, 32'd33, 32'd31,
                                 32'd1, 32'd1, 32'h5555, 32'h1, 32'd7};
    logic [31:0] v_imm  [NV] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h1234_5000, 32'h0, 32'h0};
    logic        v_immu [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        v_rdu  [NV] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0]  v_prd  [NV] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9, 6'd10, 6'd13, 6'd7};
    logic [31:0] v_exp  [NV] = '{32'h0, 32'hF000, 32'hFFF0, 32'hF0, 32'd2, 32'd1,
                                 32'd1, 32'd0, 32'h1234_5000, 32'd0, MUL_EXP};
    logic [5:0]  v_eprd [NV] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9, 6'd10, 6'd13, 6'd0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [5:0] prd);
        issue_valid_i = 1'b1;
        op_i = op;
        src1_i = a;
        src2_i = b;
        imm_i = '0;
        imm_used_i = 1'b0;
        rob_tag_i = tag;
        rd_used_i = 1'b1;
        prd_i = prd;
    endtask

    task automatic idle();
        issue_valid_i = 1'b0;
        op_i = '0;
        src1_i = '0;
        src2_i = '0;
        imm_i = '0;
        imm_used_i = 1'b0;
        rob_tag_i = '0;
        rd_used_i = 1'b0;
        prd_i = '0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        assertions++;
        if (wb_valid_o !== 1'b0 || occ_o !== 2'd0 || issue_ready_o !== 1'b1 || wb_data_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_in: valid=%b occ=%0d ready=%b data=%h, want 0 0 1 0",
                     wb_valid_o, occ_o, issue_ready_o, wb_data_o);
        end
        #19 rst_n = 1'b1;
        tick();
        assertions++;
        if (wb_valid_o !== 1'b0 || occ_o !== 2'd0 || issue_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_after: valid=%b occ=%0d ready=%b, want 0 0 1",
                     wb_valid_o, occ_o, issue_ready_o);
        end
    endtask

    task automatic test_add_latency();
        wb_ready_i = 1'b1;
        drive(4'd0, 32'd5, 32'd7, 5'd3, 6'd9);
        tick();
        idle();
        assertions++;
        if (wb_valid_o !== 1'b0 || occ_o !== 2'd1) begin
            failures++;
            $display("FAIL add_stage1: valid=%b occ=%0d, want 0 1", wb_valid_o, occ_o);
        end
        tick();
        assertions++;
        if (wb_valid_o !== 1'b1 || wb_data_o !== 32'd12 || wb_rob_tag_o !== 5'd3 ||
            wb_prd_o !== 6'd9 || wb_rd_used_o !== 1'b1) begin
            failures++;
            $display("FAIL add_wb: valid=%b data=%0d tag=%0d prd=%0d rdu=%b, want 1 12 3 9 1",
                     wb_valid_o, wb_data_o, wb_rob_tag_o, wb_prd_o, wb_rd_used_o);
        end
        tick();
        assertions++;
        if (wb_valid_o !== 1'b0 || occ_o !== 2'd0 || wb_data_o !== 32'd0 || wb_prd_o !== 6'd0) begin
            failures++;
            $display("FAIL add_drained: valid=%b occ=%0d data=%h prd=%0d, want 0 0 0 0",
                     wb_valid_o, occ_o, wb_data_o, wb_prd_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3] = '{32'hFFFF_FFFF, 32'hF800_0000, 32'd1};
        wb_ready_i = 1'b1;
        drive(4'd1, 32'd0, 32'd1, 5'd10, 6'd20);
        tick();
        drive(4'd7, 32'h8000_0000, 32'hFF, 5'd11, 6'd21);
        imm_i = 32'd4;
        imm_used_i = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            assertions++;
            if (wb_valid_o !== 1'b1 || wb_data_o !== exp[i] || wb_rob_tag_o !== 5'(10 + i)) begin
                failures++;
                $display("FAIL b2b_%0d: valid=%b data=%h tag=%0d, want 1 %h %0d",
                         i, wb_valid_o, wb_data_o, wb_rob_tag_o, exp[i], 10 + i);
            end
            if (i == 0) drive(4'd9, 32'd1, 32'd2, 5'd12, 6'd22);
            else idle();
            tick();
        end
        assertions++;
        if (wb_valid_o !== 1'b0 || occ_o !== 2'd0) begin
            failures++;
            $display("FAIL b2b_end: valid=%b occ=%0d, want 0 0", wb_valid_o, occ_o);
        end
    endtask

    task automatic test_alu_ops();
        wb_ready_i = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(v_op[i], v_a[i], v_b[i], 5'(i), v_prd[i]);
            imm_i = v_imm[i];
            imm_used_i = v_immu[i];
            rd_used_i = v_rdu[i];
            tick();
            idle();
            tick();
            assertions++;
            if (wb_valid_o !== 1'b1 || wb_data_o !== v_exp[i] || wb_prd_o !== v_eprd[i] ||
                wb_rd_used_o !== v_rdu[i]) begin
                failures++;
                $display("FAIL alu_op%0d: valid=%b data=%h prd=%0d rdu=%b, want 1 %h %0d %b",
                         v_op[i], wb_valid_o, wb_data_o, wb_prd_o, wb_rd_used_o,
                         v_exp[i], v_eprd[i], v_rdu[i]);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        wb_ready_i = 1'b0;
        drive(4'd0, 32'd1, 32'd1, 5'd1, 6'd1);
        tick();
        drive(4'd0, 32'd10, 32'd20, 5'd2, 6'd2);
        tick();
        drive(4'd0, 32'd100, 32'd1, 5'd4, 6'd4);
        for (int i = 0; i < 3; i++) begin
            assertions++;
            if (issue_ready_o !== 1'b0 || occ_o !== 2'd2 || wb_valid_o !== 1'b1 ||
                wb_data_o !== 32'd2 || wb_rob_tag_o !== 5'd1 || wb_prd_o !== 6'd1) begin
                failures++;
                $display("FAIL bp_hold%0d: ready=%b occ=%0d valid=%b data=%0d tag=%0d prd=%0d, want 0 2 1 2 1 1",
                         i, issue_ready_o, occ_o, wb_valid_o, wb_data_o, wb_rob_tag_o, wb_prd_o);
            end
            if (i < 2) tick();
        end
        wb_ready_i = 1'b1;
        #1;
        assertions++;
        if (issue_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: ready=%b, want 1", issue_ready_o);
        end
        tick();
        idle();
        assertions++;
        if (wb_valid_o !== 1'b1 || wb_data_o !== 32'd30 || wb_rob_tag_o !== 5'd2 || occ_o !== 2'd2) begin
            failures++;
            $display("FAIL bp_drain1: valid=%b data=%0d tag=%0d occ=%0d, want 1 30 2 2",
                     wb_valid_o, wb_data_o, wb_rob_tag_o, occ_o);
        end
        tick();
        assertions++;
        if (wb_valid_o !== 1'b1 || wb_data_o !== 32'd101 || wb_rob_tag_o !== 5'd4 || occ_o !== 2'd1) begin
            failures++;
            $display("FAIL bp_drain2: valid=%b data=%0d tag=%0d occ=%0d, want 1 101 4 1",
                     wb_valid_o, wb_data_o, wb_rob_tag_o, occ_o);
        end
        tick();
        assertions++;
        if (wb_valid_o !== 1'b0 || occ_o !== 2'd0) begin
            failures++;
            $display("FAIL bp_empty: valid=%b occ=%0d, want 0 0", wb_valid_o, occ_o);
        end
    endtask

    task automatic test_flush();
        logic seen;
        wb_ready_i = 1'b0;
        drive(4'd0, 32'd2, 32'd2, 5'd5, 6'd5);
        tick();
        drive(4'd0, 32'd3, 32'd3, 5'd6, 6'd6);
        tick();
        assertions++;
        if (occ_o !== 2'd2) begin
            failures++;
            $display("FAIL flush_pre_occ: occ=%0d, want 2", occ_o);
        end
        wb_ready_i = 1'b1;
        flush_i = 1'b1;
        drive(4'd0, 32'd9, 32'd9, 5'd7, 6'd7);
        tick();
        flush_i = 1'b0;
        idle();
        assertions++;
        if (wb_valid_o !== 1'b0 || occ_o !== 2'd0 || issue_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_after: valid=%b occ=%0d ready=%b, want 0 0 1",
                     wb_valid_o, occ_o, issue_ready_o);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wb_valid_o) seen = 1'b1;
        end
        assertions++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL flush_dropped: stale writeback seen=%b, want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        wb_ready_i = 1'b0;
        drive(4'd0, 32'd4, 32'd4, 5'd8, 6'd8);
        tick();
        drive(4'd0, 32'd5, 32'd5, 5'd9, 6'd9);
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        assertions++;
        if (wb_valid_o !== 1'b0 || occ_o !== 2'd0 || wb_data_o !== 32'd0 ||
            wb_rob_tag_o !== 5'd0 || issue_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid: valid=%b occ=%0d data=%h tag=%0d ready=%b, want 0 0 0 0 1",
                     wb_valid_o, occ_o, wb_data_o, wb_rob_tag_o, issue_ready_o);
        end
        wb_ready_i = 1'b1;
        tick();
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wb_valid_o || occ_o != 2'd0) seen = 1'b1;
        end
        assertions++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_stale: stale activity seen=%b, want 0", seen);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add_latency();
        test_back_to_back();
        test_alu_ops();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/alu_fu_pipe.md
ALU_FU_PIPE -- requirements
Module: alu_fu_pipe

Interface
- REQ-001: Parameter XLEN, default 32, data width of operands and result.
- REQ-002: Parameter STAGES, default 2, pipeline depth; legal range 1..4.
- REQ-003: Parameter TAG_W, default 5, ROB tag width.
- REQ-004: Parameter PREG_W, default 6, physical register index width.
- REQ-005: clk  input  1  single clock; all state updates on rising edge.
- REQ-006: rst_n  input  1  asynchronous, active-low reset.
- REQ-007: flush_i  input  1  squash all in-flight operations.
- REQ-008: issue_valid_i  input  1  issue request.
- REQ-009: issue_ready_o  output  1  FU can accept an issue this cycle.
- REQ-010: op_i  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 LUI, 11 MUL, 12-15 reserved.
- REQ-011: src1_i, src2_i  input  XLEN  operands; imm_i  input  XLEN  immediate.
- REQ-012: imm_used_i  input  1  select imm_i instead of src2_i as operand B.
- REQ-013: rob_tag_i  input  TAG_W; rd_used_i  input  1; prd_i  input  PREG_W.
- REQ-014: wb_valid_o  output  1; wb_ready_i  input  1  writeback handshake.
- REQ-015: wb_rob_tag_o  output  TAG_W; wb_rd_used_o  output  1; wb_prd_o  output  PREG_W; wb_data_o  output  XLEN.
- REQ-016: occ_o  output  clog2(STAGES+1)  number of valid in-flight entries.

Function
- REQ-017: Issue accepted iff issue_valid_i && issue_ready_o && !flush_i.
- REQ-018: Result computed combinationally from issue inputs and captured into stage 1 on acceptance; stages 2..STAGES carry it unchanged.
- REQ-019: Latency with wb_ready_i held high: accepted at edge N, wb_valid_o high after edge N+STAGES-1 (STAGES=1: visible the cycle after issue).
- REQ-020: Throughput one op per cycle when wb_ready_i high.
- REQ-021: Stage k advances when stage k+1 is empty or advancing; last stage advances when wb_ready_i high; issue_ready_o = stage 1 empty or advancing.
- REQ-022: While wb_valid_o && !wb_ready_i, all wb_* outputs hold stable; no bubble is collapsed out of order; ordering strictly FIFO.
- REQ-023: Operand B = imm_used_i ? imm_i : src2_i.
- REQ-024: Shifts use B[clog2(XLEN)-1:0]; SRA arithmetic; SLT signed, SLTU unsigned, result 1 or 0.
- REQ-025: ADD/SUB wrap modulo 2^XLEN; LUI result = operand B.
- REQ-026: Reserved op codes produce result 0 and still write back.
- REQ-027: wb_prd_o = 0 whenever wb_rd_used_o = 0; all wb_* payload = 0 when wb_valid_o = 0.
- REQ-028: flush_i high at an edge clears every stage valid; issue in same cycle is dropped; wb_valid_o low the next cycle regardless of wb_ready_i.
- REQ-029: occ_o increments on accepted issue, decrements on wb handshake, both same cycle leaves it unchanged; zero after flush; never exceeds STAGES.

Reset
- REQ-030: rst_n low asynchronously clears all stage valids and payloads; wb_valid_o = 0, wb_* = 0, occ_o = 0, issue_ready_o = 1 while in reset and first cycle after.
- REQ-031: Reset mid-operation discards all in-flight ops; no writeback issued for them.

Configuration
- REQ-032: Macro ALU_FU_PIPE_MUL_EN defined: op 11 yields low XLEN bits of src1 * operand B (unsigned product), same latency as other ops.
- REQ-033: Macro undefined: no multiplier instantiated; op 11 treated as reserved (result 0, REQ-026).

Verification
- REQ-034: STAGES=2, wb_ready_i=1, issue ADD 5+7 tag 3 prd 9 -> wb_valid_o one cycle later edge+1, data 12, tag 3, prd 9.
- REQ-035: Back-to-back SUB 0-1, SRA 0x80000000>>4, SLTU 1<2 -> consecutive writebacks 0xFFFFFFFF, 0xF8000000, 1 in order.
- REQ-036: wb_ready_i=0, issue 3 ops with STAGES=2 -> third issue blocked (issue_ready_o=0), occ_o=2, wb_* stable; release -> in-order drain.
- REQ-037: Flush with occ_o=2 plus simultaneous issue -> next cycle wb_valid_o=0, occ_o=0, dropped op never written back.
- REQ-038: rd_used_i=0, prd_i=7 -> wb_prd_o=0; op 11 with 6*7 -> 42 if ALU_FU_PIPE_MUL_EN else 0.
- REQ-039: Assert rst_n low asynchronously mid-burst -> wb_valid_o and occ_o zero immediately, no stale writeback after release.
